led_share_arbiter: RTL
======================

# led_share_arbiter

Shares the board's 2-bit LED output among up to N_REQ requesters (status, error, heartbeat and debug sources) on the PLL-derived clock. A round-robin arbiter grants the LEDs to one requester at a time and shows its latched pattern for a fixed hold period on a prescaled tick timebase. A blank gap follows each grant before the next arbitration. The block sits between the status sources and the LED pins.

## Interface
- N_REQ, 4, number of requesters (2..8)
- PRESCALE, 50000, clk cycles per tick (>= 2)
- HOLD_TICKS, 100, ticks a grant is held (>= 1)
- clk  in  1  system clock (PLL output domain)
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  level request per requester; must stay high until gnt or it is ignored
- pat  in  2*N_REQ  LED pattern, requester i on pat[2i+1:2i]
- gnt  out  N_REQ  one-hot grant, registered
- done  out  1  one-cycle pulse when a grant ends
- busy  out  1  high in GRANT or GAP
- led  out  2  LED drive, registered

## Operation
- States: IDLE, GRANT, GAP.
- IDLE: if any req bit is set, pick the first set bit strictly after last_owner, wrapping modulo N_REQ. Next cycle:
  - enter GRANT;
  - gnt[owner]=1;
  - latch pat[owner] into the pattern register;
  - clear the prescaler and hold counter.
- GRANT:
  - led = latched pattern. Later changes on pat are ignored.
  - Prescaler counts 0..PRESCALE-1. tick fires when the count is PRESCALE-1, then the count wraps to 0.
  - The hold counter increments on each tick.
  - When the hold counter reaches HOLD_TICKS, go to GAP.
  - Early release: req[owner] sampled low also goes to GAP on the next cycle. This takes priority over tick in the same cycle.
- Entering GAP:
  - gnt=0, led=0, done pulses for exactly one cycle;
  - last_owner = owner;
  - prescaler is cleared.
- GAP lasts one tick (PRESCALE cycles), then returns to IDLE. Requests are not sampled during GAP.
- Round robin: after reset, last_owner = N_REQ-1, so requester 0 has first priority.
- A requester that re-requests immediately is served again only if no other requester is pending at the IDLE sample.
- Counter widths:
  - prescaler: $clog2(PRESCALE);
  - hold counter: $clog2(HOLD_TICKS+1);
  - no overflow is possible.

## Timing
- Reset values (asynchronous, any state): state=IDLE, gnt=0, led=2'b00, done=0, busy=0, last_owner=N_REQ-1, all counters 0.
- Reset asserted mid-grant: outputs clear immediately and asynchronously. No done pulse.
- Latency from req rising edge (sampled in IDLE) to gnt/led valid is one clk.
- Full hold: gnt is high for exactly HOLD_TICKS*PRESCALE cycles. The done pulse is on the first cycle gnt is low.
- Gap: led=0 and busy=1 for PRESCALE cycles after gnt falls. The earliest next gnt comes PRESCALE+1 cycles after gnt falls.
- Early release: gnt falls one cycle after req[owner] is sampled low.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- LED_SHARE_BLINK_EN defined:
  - during GRANT, led toggles between the latched pattern and 2'b00 on every tick, starting with the pattern;
  - the hold counter and gnt timing are unchanged.
- LED_SHARE_BLINK_EN undefined:
  - led shows the latched pattern steadily for the whole grant;
  - no blink logic is synthesized.

## Test plan
All scenarios use N_REQ=4, PRESCALE=4, HOLD_TICKS=3.
- Reset: hold rst_n low with req=4'hF. Required: gnt=0, led=0, busy=0, done=0. Assert rst_n low mid-GRANT: outputs clear within the same cycle.
- Single grant:
  - Stimulus: req=4'b0100, pat[5:4]=2'b10.
  - gnt=4'b0100 one cycle later, and led=2'b10 for 12 cycles.
  - done pulses once on the cycle gnt falls.
  - led=0 for a 4-cycle gap, then busy=0.
- Round robin:
  - Stimulus: req=4'b1011 held high.
  - Required grant order: 0, 1, 3, 0.
  - Each grant is 12 cycles, and consecutive grants are separated by 5 cycles.
- Early release: requester 2 is granted and drops req after 5 cycles. Required: gnt falls 1 cycle later, done pulses, and the 4-cycle gap follows.
- Pattern latch: change pat for the owner mid-GRANT. Required: led keeps the value latched at grant.
- Blink (LED_SHARE_BLINK_EN defined): pat=2'b11. Required: led sequence 11, 00, 11, each for 4 cycles; gnt is still 12 cycles.

Source files
------------

// File: rtl/led_share_arbiter_if.sv
// Bundle of request/pattern inputs and grant/LED outputs for led_share_arbiter.
// The arbiter connects to the slave modport. Status sources drive through the master modport.
interface led_share_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   req;
   logic [2*N_REQ-1:0] pat;
   logic [N_REQ-1:0]   gnt;
   logic               done;
   logic               busy;
   logic [1:0]         led;

   modport master (output req, output pat, input gnt, input done, input busy, input led);
   modport slave  (input req, input pat, output gnt, output done, output busy, output led);
endinterface

// File: rtl/led_share_arbiter.sv
// Round-robin sharing of the 2-bit board LEDs among N_REQ status sources.
// Each requester wins the LEDs for HOLD_TICKS prescaled ticks.
// Every grant is followed by a one-tick blank gap before the next arbitration.
// Optional feature: define LED_SHARE_BLINK_EN to blink the granted pattern on every tick.
module led_share_arbiter #(
   parameter int N_REQ      = 4,
   parameter int PRESCALE   = 50000,
   parameter int HOLD_TICKS = 100
) (
   input  logic               clk,
   input  logic               rst_n,
   led_share_arbiter_if.slave ifc
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int PW = $clog2(PRESCALE);
   localparam int HW = $clog2(HOLD_TICKS + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   logic [1:0]       r_state;
   logic [IW-1:0]    r_owner;
   logic [IW-1:0]    r_lastOwner;
   logic [PW-1:0]    r_presc;
   logic [HW-1:0]    r_hold;
   logic [N_REQ-1:0] r_gnt;
   logic [1:0]       r_led;
   logic             r_done;
   logic             r_busy;
`ifdef LED_SHARE_BLINK_EN
   logic [1:0]       r_pat;
   logic             r_blinkOff;
`endif

   logic             w_anyReq;
   logic             w_found;
   logic [IW-1:0]    w_cand;
   logic [IW-1:0]    w_nextOwner;
   logic [1:0]       w_nextPat;
   logic             w_tick;
   logic             w_toGap;

   // Pick the first pending requester after the previous owner, wrapping around, and fetch its pattern.
   always_comb begin
      w_anyReq    = |ifc.req;
      w_found     = 1'b0;
      w_cand      = '0;
      w_nextOwner = r_lastOwner;
      w_nextPat   = 2'b00;
      for (int k = 1; k <= N_REQ; k++) begin
         w_cand = IW'((int'(r_lastOwner) + k) % N_REQ);
         if (!w_found && ifc.req[w_cand]) begin
            w_found     = 1'b1;
            w_nextOwner = w_cand;
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (w_nextOwner == IW'(i)) begin
            w_nextPat = ifc.pat[2*i +: 2];
         end
      end
   end

   // Decode the prescaler tick and the end of a grant (an early release wins over a hold expiry).
   always_comb begin
      w_tick  = (r_presc == PW'(PRESCALE - 1));
      w_toGap = 1'b0;
      if (r_state == S_GRANT) begin
         w_toGap = !ifc.req[r_owner] || (w_tick && (r_hold == HW'(HOLD_TICKS - 1)));
      end
   end

   // Arbitration FSM with the prescaler, hold counter and registered LED/grant outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_owner     <= '0;
         r_lastOwner <= IW'(N_REQ - 1);
         r_presc     <= '0;
         r_hold      <= '0;
         r_gnt       <= '0;
         r_led       <= 2'b00;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
`ifdef LED_SHARE_BLINK_EN
         r_pat       <= 2'b00;
         r_blinkOff  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_anyReq) begin
                  r_state <= S_GRANT;
                  r_owner <= w_nextOwner;
                  r_gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << w_nextOwner;
                  r_led   <= w_nextPat;
                  r_busy  <= 1'b1;
                  r_presc <= '0;
                  r_hold  <= '0;
`ifdef LED_SHARE_BLINK_EN
                  r_pat      <= w_nextPat;
                  r_blinkOff <= 1'b0;
`endif
               end
            end
            S_GRANT: begin
               if (w_toGap) begin
                  r_state     <= S_GAP;
                  r_gnt       <= '0;
                  r_led       <= 2'b00;
                  r_done      <= 1'b1;
                  r_lastOwner <= r_owner;
                  r_presc     <= '0;
               end else if (w_tick) begin
                  r_presc <= '0;
                  r_hold  <= r_hold + 1'b1;
`ifdef LED_SHARE_BLINK_EN
                  r_blinkOff <= ~r_blinkOff;
                  r_led      <= r_blinkOff ? r_pat : 2'b00;
`endif
               end else begin
                  r_presc <= r_presc + 1'b1;
               end
            end
            S_GAP: begin
               if (w_tick) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_presc <= '0;
               end else begin
                  r_presc <= r_presc + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_gnt   <= '0;
               r_led   <= 2'b00;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign ifc.gnt  = r_gnt;
   assign ifc.led  = r_led;
   assign ifc.done = r_done;
   assign ifc.busy = r_busy;

endmodule
